rf_sb_param: RTL
================

// Module: rf_sb_param
// PURPOSE
//   Parametrised pipeline register file: 2 async read ports, 1 sync write port.
//   Adds optional write-to-read bypass, a per-register scoreboard (busy bits) for
//   hazard detection and a sequential bulk-clear engine.
//   Sits in the decode stage of the pipelined CPU; writeback drives the write port.
// PARAMETERS
//   DW       32  data width in bits
//   AW       5   address width; DEPTH = 2**AW registers (localparam)
//   ZERO_REG 1   1: register 0 always reads 0 and ignores writes and scoreboard set
//   BYPASS   1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//   clk      in  1   clock, rising edge
//   rst      in  1   asynchronous, active-high reset
//   ra1      in  AW  read address, port 1
//   ra2      in  AW  read address, port 2
//   rd1      out DW  read data, port 1 (combinational)
//   rd2      out DW  read data, port 2 (combinational)
//   busy1    out 1   scoreboard bit of ra1 (combinational)
//   busy2    out 1   scoreboard bit of ra2 (combinational)
//   we       in  1   write enable
//   wa       in  AW  write address
//   wd       in  DW  write data
//   sb_set   in  1   issue: mark sb_addr busy (pending producer)
//   sb_addr  in  AW  destination register of the issuing instruction
//   clr_req  in  1   start bulk clear (sampled only in IDLE)
//   clr_busy out 1   high while the clear engine runs
// BEHAVIOUR
//   - Reset: all registers 0, all busy bits 0, FSM = IDLE, counter 0, clr_busy 0.
//     Reset during CLEAR aborts it immediately. rd*/busy* are 0 while rst is high.
//   - Write: at posedge clk when we=1 in IDLE, rf[wa] <= wd; also clears busy[wa].
//     With ZERO_REG=1, writes to wa=0 are dropped.
//   - Read: rd = rf[ra]. With ZERO_REG=1, ra=0 returns 0.
//     With BYPASS=1: if we && wa==ra (wa!=0 when ZERO_REG), rd = wd (same cycle).
//     With BYPASS=0: new value visible the cycle after the write.
//   - Scoreboard: sb_set at posedge sets busy[sb_addr].
//     If we clears and sb_set sets the same address in one cycle, set wins.
//     busy_n = busy[ra_n]; with BYPASS=1 it reads 0 when a write to ra_n is
//     presented in that cycle and sb_set does not target ra_n.
//   - Clear FSM, two states:
//     IDLE  -> CLEAR when clr_req=1; all busy bits cleared on entry, cnt <= 0.
//     CLEAR -> each cycle rf[cnt] <= 0, cnt++; after cnt == DEPTH-1 is written,
//              go to IDLE. Duration is exactly DEPTH cycles.
//     clr_busy = (state==CLEAR). In CLEAR: we and sb_set are ignored,
//     rd*/busy* read 0, clr_req is ignored. cnt wraps from DEPTH-1 to 0 on exit.
//   - No other arithmetic. Widths are exact DW/AW; no sign extension.
// CONFIGURATION
//   RF_TRACE_EN defined: each posedge where a write commits, $display prints
//     "RF W R[<wa hex>]=<wd hex>", then dumps all DEPTH registers 8 per line.
//     Prints "RF CLEAR start/done" at the FSM transitions. Simulation only.
//   RF_TRACE_EN undefined: no $display code; the design is fully synthesizable.
//   Functional behaviour is identical with and without the macro.
// TESTING
//   1 reset: rst=1 with ra1=3 -> rd1=0, busy1=0, clr_busy=0; after release
//     all 32 registers read 0.
//   2 write/bypass: we=1,wa=5,wd=32'hDEADBEEF,ra1=5 -> rd1=DEADBEEF same cycle
//     (BYPASS=1); with BYPASS=0 rd1=0 then DEADBEEF next cycle.
//   3 zero reg: we=1,wa=0,wd=32'h1234 then ra1=0 -> rd1=0; sb_set with
//     sb_addr=0 -> busy1=0.
//   4 scoreboard: sb_set,sb_addr=7 -> busy(ra=7)=1 next cycle; we,wa=7 with
//     sb_set,sb_addr=7 in one cycle -> busy stays 1; we,wa=7 alone -> busy 0.
//   5 clear: fill r1..r31 with index value, pulse clr_req -> clr_busy high for
//     exactly 32 cycles, a write during it is ignored, afterwards all reads 0.
//   6 reset mid-clear: assert rst 10 cycles into CLEAR -> clr_busy=0
//     immediately, all registers 0, FSM in IDLE, next clr_req restarts at cnt=0.

Source files
------------

// File: rtl/rf_sb_param.sv
`default_nettype none
// ============================================================================
// Module   : rf_sb_param
// Purpose  : Pipeline register file for the decode stage. It has two
//            combinational read ports and one synchronous write port driven by
//            writeback. It also has an optional write-to-read bypass, a
//            per-register busy scoreboard for hazard detection, and a
//            sequential bulk-clear engine.
// Params   : DW       data width
//            AW       address width, DEPTH = 2**AW registers
//            ZERO_REG 1: register 0 reads 0 and ignores writes/scoreboard set
//            BYPASS   1: a same-cycle write is forwarded to matching readers
// Ports    : clk, rst        clock (rising edge), async active-high reset
//            ra1/ra2         read addresses
//            rd1/rd2         read data (combinational)
//            busy1/busy2     scoreboard bit of ra1/ra2 (combinational)
//            we/wa/wd        write enable / address / data
//            sb_set/sb_addr  mark sb_addr busy (issue of a pending producer)
//            clr_req         start bulk clear (sampled only in IDLE)
//            clr_busy        high while the clear engine runs
// Macro    : RF_TRACE_EN - when defined, prints simulation trace messages for
//            writes and clear start/done. It has no functional effect.
// Revision : 1.0 - initial release
// ============================================================================
module rf_sb_param #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_addr,
    input  logic          clr_req,
    output logic          clr_busy
);

    localparam int            DEPTH  = 2**AW;
    localparam logic [AW-1:0] c_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] c_ONE  = AW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic [DW-1:0]       r_rf [DEPTH];
    logic [DEPTH-1:0]    r_busy;

    logic                w_idle;
    logic                w_wr_ok;
    logic                w_set_ok;
    logic [DEPTH-1:0]    w_busy_nxt;

    assign w_idle   = (r_state == S_IDLE);
    // Effective write / scoreboard-set: only in IDLE, and never to r0 when
    // register 0 is hard-wired.
    assign w_wr_ok  = we     && w_idle && !(ZERO_REG && (wa == '0));
    assign w_set_ok = sb_set && w_idle && !(ZERO_REG && (sb_addr == '0));

    assign clr_busy = (r_state == S_CLEAR);

    // Scoreboard next state: a write clears its bit first and then an issue
    // sets its bit, so a set wins over a clear to the same register.
    // Entering CLEAR wipes the whole scoreboard.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wa] = 1'b0;
        end
        if (w_set_ok) begin
            w_busy_nxt[sb_addr] = 1'b1;
        end
        if (w_idle && clr_req) begin
            w_busy_nxt = '0;
        end
    end

    // Read ports. Both ports read 0 during reset and while clearing.
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!rst && w_idle) begin
            rd1   = r_rf[ra1];
            rd2   = r_rf[ra2];
            busy1 = r_busy[ra1];
            busy2 = r_busy[ra2];
            if (ZERO_REG && (ra1 == '0)) begin
                rd1 = '0;
            end
            if (ZERO_REG && (ra2 == '0)) begin
                rd2 = '0;
            end
            // A write in flight resolves the hazard, unless the same
            // register is being re-issued in this cycle.
            if (BYPASS && w_wr_ok && (wa == ra1)) begin
                rd1 = wd;
                if (!(w_set_ok && (sb_addr == ra1))) begin
                    busy1 = 1'b0;
                end
            end
            if (BYPASS && w_wr_ok && (wa == ra2)) begin
                rd2 = wd;
                if (!(w_set_ok && (sb_addr == ra2))) begin
                    busy2 = 1'b0;
                end
            end
        end
    end

    // Storage, scoreboard and clear engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ok) begin
                        r_rf[wa] <= wd;
                    end
                    r_busy <= w_busy_nxt;
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    // One register per cycle; the counter wraps back to 0
                    // as the last register is cleared.
                    r_rf[r_cnt] <= '0;
                    r_cnt       <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RF_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (w_wr_ok) begin
                $display("RF W R[%h]=%h", wa, wd);
                // Dump shows the contents as they will be after this write.
                for (int i = 0; i < DEPTH; i += 8) begin
                    string s;
                    s = "";
                    for (int j = 0; j < 8; j++) begin
                        if (i + j < DEPTH) begin
                            s = {s, $sformatf(" %h", ((i + j) == int'(wa)) ? wd : r_rf[i + j])};
                        end
                    end
                    $display("RF  %0d:%s", i, s);
                end
            end
            if (w_idle && clr_req) begin
                $display("RF CLEAR start");
            end
            if (!w_idle && (r_cnt == c_LAST)) begin
                $display("RF CLEAR done");
            end
        end
    end
`endif

endmodule
`default_nettype wire
